// File: rtl/serial_bank_mapper.sv
// serial_bank_mapper: serial-load bank mapper for the NES cartridge FPGA.
// CPU writes to $8000-$FFFF shift one bit per write into a load register;
// the final bit commits the value to control, chr0, chr1 or prg.
// State updates on the falling edge of m2; address outputs are combinational.
// Optional build macro: SERIAL_MAPPER_SXROM_EN adds the SXROM outer PRG bank
// (chr0[4]) and WRAM bank (chr0[3:2]); it needs PRG_ADDR_BITS >= 19.
module serial_bank_mapper #(
    parameter int unsigned SHIFT_LEN      = 5,
    parameter int unsigned PRG_ADDR_BITS  = 19,
    parameter int unsigned CHR_ADDR_BITS  = 17,
    parameter int unsigned WRAM_ADDR_BITS = 15,
    parameter int unsigned FILTER_CONSEC  = 1
) (
    input  logic                      m2,
    input  logic                      reset_n,
    input  logic [15:0]               cpu_addr,
    input  logic [7:0]                cpu_data_in,
    input  logic                      cpu_rw,
    input  logic [13:0]               ppu_addr,
    input  logic                      ppu_rd,
    input  logic                      ppu_wr,
    input  logic                      chr_ram,
    output logic [PRG_ADDR_BITS-1:0]  prg_addr,
    output logic                      prg_oe,
    output logic [WRAM_ADDR_BITS-1:0] wram_addr,
    output logic                      wram_ce,
    output logic [CHR_ADDR_BITS-1:0]  chr_addr,
    output logic                      chr_ce,
    output logic                      chr_oe,
    output logic                      chr_we,
    output logic                      ciram_ce,
    output logic                      ciram_a10,
    output logic                      busy
);

    localparam int unsigned REG_W      = 5;
    localparam int unsigned CNT_W      = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
    localparam int unsigned PRG_FULL_W = 19;
    localparam int unsigned CHR_FULL_W = 17;
    localparam int unsigned WRAM_FULL_W = 15;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_LEN - 1);
    localparam bit FILTER_EN = (FILTER_CONSEC != 0);
    localparam logic [REG_W-1:0] CTRL_RESET = 5'b01100;

    // Mapper registers
    logic [REG_W-1:0]     control_q, control_d;
    logic [REG_W-1:0]     chr0_q, chr0_d;
    logic [REG_W-1:0]     chr1_q, chr1_d;
    logic [REG_W-1:0]     prg_q, prg_d;
    logic [SHIFT_LEN-1:0] load_q, load_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wr_prev_q, wr_prev_d;

    logic                 wr_cycle;
    logic                 wr_accept;
    logic [SHIFT_LEN-1:0] load_shift;
    logic [REG_W-1:0]     commit_val;

    logic                 outer;
    logic [1:0]           wbank;
    logic [3:0]           ps;
    logic [4:0]           cs;
    logic [PRG_FULL_W-1:0]  prg_full;
    logic [CHR_FULL_W-1:0]  chr_full;
    logic [WRAM_FULL_W-1:0] wram_full;

    // Data bits 6:1 carry no meaning; load_q[0] is shifted out, never read.
    logic unused_bits;
    assign unused_bits = ^{cpu_data_in[6:1], load_q[0]};

    // Write qualification: a CPU write to $8000+, optionally filtering RMW doubles
    assign wr_cycle   = cpu_addr[15] && !cpu_rw;
    assign wr_accept  = wr_cycle && !(FILTER_EN && wr_prev_q);
    assign load_shift = {cpu_data_in[0], load_q[SHIFT_LEN-1:1]};
    assign commit_val = REG_W'(load_shift);

    // State register: falling edge of m2, async active-low reset
    always_ff @(negedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            control_q <= CTRL_RESET;
            chr0_q    <= '0;
            chr1_q    <= '0;
            prg_q     <= '0;
            load_q    <= '0;
            cnt_q     <= '0;
            wr_prev_q <= 1'b0;
        end else begin
            control_q <= control_d;
            chr0_q    <= chr0_d;
            chr1_q    <= chr1_d;
            prg_q     <= prg_d;
            load_q    <= load_d;
            cnt_q     <= cnt_d;
            wr_prev_q <= wr_prev_d;
        end
    end

    // Next state: bit counter drives shift, reset-bit and commit
    always_comb begin
        control_d = control_q;
        chr0_d    = chr0_q;
        chr1_d    = chr1_q;
        prg_d     = prg_q;
        load_d    = load_q;
        cnt_d     = cnt_q;
        wr_prev_d = wr_cycle;

        if (wr_accept) begin
            if (cpu_data_in[7]) begin
                cnt_d     = '0;
                load_d    = '0;
                control_d = control_q | CTRL_RESET;
            end else if (cnt_q != CNT_LAST) begin
                load_d = load_shift;
                cnt_d  = cnt_q + CNT_W'(1);
            end else begin
                cnt_d  = '0;
                load_d = '0;
                case (cpu_addr[14:13])
                    2'd0:    control_d = commit_val;
                    2'd1:    chr0_d    = commit_val;
                    2'd2:    chr1_d    = commit_val;
                    default: prg_d     = commit_val;
                endcase
            end
        end
    end

    // SXROM extension: outer PRG bank and WRAM bank from chr0
`ifdef SERIAL_MAPPER_SXROM_EN
    assign outer = chr0_q[4];
    assign wbank = chr0_q[3:2];
`else
    assign outer = 1'b0;
    assign wbank = 2'b00;
`endif

    // PRG 16K slot select by PRG mode
    always_comb begin
        ps = 4'h0;
        case (control_q[3:2])
            2'b10:   ps = cpu_addr[14] ? prg_q[3:0] : 4'h0;
            2'b11:   ps = cpu_addr[14] ? 4'hF : prg_q[3:0];
            default: ps = {prg_q[3:1], cpu_addr[14]};
        endcase
    end

    // CHR 4K select by CHR mode
    always_comb begin
        cs = 5'h00;
        if (control_q[4]) begin
            cs = ppu_addr[12] ? chr1_q : chr0_q;
        end else begin
            cs = {chr0_q[4:1], ppu_addr[12]};
        end
    end

    // Nametable mirroring
    always_comb begin
        ciram_a10 = 1'b0;
        case (control_q[1:0])
            2'b00:   ciram_a10 = 1'b0;
            2'b01:   ciram_a10 = 1'b1;
            2'b10:   ciram_a10 = ppu_addr[10];
            default: ciram_a10 = ppu_addr[11];
        endcase
    end

    // Address composition, zero-extended or trimmed to the configured widths
    assign prg_full  = {outer, ps, cpu_addr[13:0]};
    assign chr_full  = chr_ram ? {4'b0000, ppu_addr[12:0]} : {cs, ppu_addr[11:0]};
    assign wram_full = {wbank, cpu_addr[12:0]};

    assign prg_addr  = PRG_ADDR_BITS'(prg_full);
    assign chr_addr  = CHR_ADDR_BITS'(chr_full);
    assign wram_addr = WRAM_ADDR_BITS'(wram_full);

    // Chip selects and strobes
    assign prg_oe   = cpu_rw && cpu_addr[15];
    assign wram_ce  = (cpu_addr[15:13] == 3'b011) && !prg_q[4];
    assign ciram_ce = !ppu_addr[13];
    assign chr_ce   = !ppu_addr[13];
    assign chr_oe   = !ppu_rd;
    assign chr_we   = chr_ram && !ppu_wr;
    assign busy     = (cnt_q != '0);

endmodule
